// File: rtl/sent_tx_pkg.sv
// Shared SENT TX CRC definitions: generator mode codes, done codes, length and FSM encodings.
// Also holds the fast-channel masking helpers used when presenting a job to the generator.
package sent_tx_pkg;

    localparam int unsigned DATA_W   = 24;
    localparam int unsigned MODE_W   = 3;
    localparam int unsigned DONE_W   = 2;
    localparam int unsigned FC_CRC_W = 4;
    localparam int unsigned SC_CRC_W = 6;

    localparam logic [MODE_W-1:0] CRC_OFF = 3'b000;
    localparam logic [MODE_W-1:0] CRC_FC6 = 3'b001;
    localparam logic [MODE_W-1:0] CRC_FC4 = 3'b010;
    localparam logic [MODE_W-1:0] CRC_FC3 = 3'b011;
    localparam logic [MODE_W-1:0] CRC_SER = 3'b101;

    localparam logic [DONE_W-1:0] DONE_NONE = 2'b00;
    localparam logic [DONE_W-1:0] DONE_4B   = 2'b01;
    localparam logic [DONE_W-1:0] DONE_6B   = 2'b10;

    typedef enum logic [1:0] {
        FC_LEN3    = 2'd0,
        FC_LEN4    = 2'd1,
        FC_LEN6    = 2'd2,
        FC_LEN_INV = 2'd3
    } fc_len_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Identity of the job currently owning the generator
    typedef struct packed {
        logic    is_sc;
        fc_len_e len;
    } job_t;

    function automatic logic [MODE_W-1:0] fc_mode(input fc_len_e len);
        case (len)
            FC_LEN3: return CRC_FC3;
            FC_LEN4: return CRC_FC4;
            FC_LEN6: return CRC_FC6;
            default: return CRC_OFF;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] fc_mask(input fc_len_e len, input logic [DATA_W-1:0] d);
        case (len)
            FC_LEN3: return {12'h000, d[11:0]};
            FC_LEN4: return {8'h00, d[15:0]};
            FC_LEN6: return d;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/sent_tx_rr_arb2.sv
// Two-input round-robin arbiter between fast (fc) and slow (sc) channel requesters.
// Holds the served-last flag; resets to slow so fast wins the first tie.
module sent_tx_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_fc_i,
    input  logic req_sc_i,
    input  logic upd_i,
    input  logic upd_sc_i,
    output logic win_vld_c_o,
    output logic win_sc_c_o
);

    logic last_sc_q;
    logic last_sc_d;

    always_comb begin
        last_sc_d = last_sc_q;
        if (upd_i) begin
            last_sc_d = upd_sc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sc_q <= 1'b1;
        end else begin
            last_sc_q <= last_sc_d;
        end
    end

    // Slow wins alone, or on a tie when fast was served last
    assign win_vld_c_o = req_fc_i | req_sc_i;
    assign win_sc_c_o  = req_sc_i & (~req_fc_i | ~last_sc_q);

endmodule

// File: rtl/sent_tx_crc_ctrl.sv
// Shares one SENT TX CRC generator between the fast-channel and slow-channel builders.
// One job at a time: arbitrate, issue mode code and data, wait for done, return the CRC.
module sent_tx_crc_ctrl
    import sent_tx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4
) (
    input  logic                clk_tx,
    input  logic                reset_n_tx,
    input  logic                fc_req_i,
    input  logic [1:0]          fc_len_i,
    input  logic [DATA_W-1:0]   fc_data_i,
    output logic                fc_gnt_o,
    output logic [FC_CRC_W-1:0] fc_crc_o,
    output logic                fc_crc_valid_o,
    input  logic                sc_req_i,
    input  logic [DATA_W-1:0]   sc_data_i,
    output logic                sc_gnt_o,
    output logic [SC_CRC_W-1:0] sc_crc_o,
    output logic                sc_crc_valid_o,
    output logic [MODE_W-1:0]   enable_crc_gen_o,
    output logic [DATA_W-1:0]   data_gen_crc_o,
    input  logic [SC_CRC_W-1:0] crc_gen_i,
    input  logic [DONE_W-1:0]   done_i,
    output logic                busy_o,
    output logic                err_o
);

    localparam int unsigned CNT_W   = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYC - 1);

    state_e               state_q, state_d;
    job_t                 job_q, job_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 fc_gnt_q, fc_gnt_d;
    logic                 sc_gnt_q, sc_gnt_d;
    logic [FC_CRC_W-1:0]  fc_crc_q, fc_crc_d;
    logic [SC_CRC_W-1:0]  sc_crc_q, sc_crc_d;
    logic                 fc_vld_q, fc_vld_d;
    logic                 sc_vld_q, sc_vld_d;
    logic [MODE_W-1:0]    en_q, en_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 arb_vld_c;
    logic                 arb_sc_c;
    logic                 arb_upd_c;
    logic [DONE_W-1:0]    exp_done_c;
    fc_len_e              fc_len_c;

    sent_tx_rr_arb2 u_arb (
        .clk         (clk_tx),
        .rst_n       (reset_n_tx),
        .req_fc_i    (fc_req_i),
        .req_sc_i    (sc_req_i),
        .upd_i       (arb_upd_c),
        .upd_sc_i    (job_q.is_sc),
        .win_vld_c_o (arb_vld_c),
        .win_sc_c_o  (arb_sc_c)
    );

    assign fc_len_c   = fc_len_e'(fc_len_i);
    assign exp_done_c = job_q.is_sc ? DONE_6B : DONE_4B;

    // Next-state and registered-output decode; outputs are set on the edge entering their state
    always_comb begin
        state_d   = state_q;
        job_d     = job_q;
        cnt_d     = cnt_q;
        fc_gnt_d  = 1'b0;
        sc_gnt_d  = 1'b0;
        fc_crc_d  = fc_crc_q;
        sc_crc_d  = sc_crc_q;
        fc_vld_d  = 1'b0;
        sc_vld_d  = 1'b0;
        en_d      = CRC_OFF;
        data_d    = data_q;
        err_d     = 1'b0;
        arb_upd_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld_c) begin
                    state_d     = ST_ISSUE;
                    job_d.is_sc = arb_sc_c;
                    job_d.len   = fc_len_c;
                    fc_gnt_d    = ~arb_sc_c;
                    sc_gnt_d    = arb_sc_c;
                    if (arb_sc_c) begin
                        en_d   = CRC_SER;
                        data_d = sc_data_i;
                    end else if (fc_len_c == FC_LEN_INV) begin
                        err_d  = 1'b1;
                    end else begin
                        en_d   = fc_mode(fc_len_c);
                        data_d = fc_mask(fc_len_c, fc_data_i);
                    end
                end
            end
            ST_ISSUE: begin
                arb_upd_c = 1'b1;
                cnt_d     = '0;
                if (!job_q.is_sc && job_q.len == FC_LEN_INV) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_i != DONE_NONE) begin
                    if (done_i == exp_done_c) begin
                        state_d = ST_RESP;
                        if (job_q.is_sc) begin
                            sc_crc_d = crc_gen_i;
                            sc_vld_d = 1'b1;
                        end else begin
                            fc_crc_d = crc_gen_i[FC_CRC_W-1:0];
                            fc_vld_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end else if (cnt_q >= CNT_TO) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            state_q  <= ST_IDLE;
            job_q    <= '0;
            cnt_q    <= '0;
            fc_gnt_q <= 1'b0;
            sc_gnt_q <= 1'b0;
            fc_crc_q <= '0;
            sc_crc_q <= '0;
            fc_vld_q <= 1'b0;
            sc_vld_q <= 1'b0;
            en_q     <= CRC_OFF;
            data_q   <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            job_q    <= job_d;
            cnt_q    <= cnt_d;
            fc_gnt_q <= fc_gnt_d;
            sc_gnt_q <= sc_gnt_d;
            fc_crc_q <= fc_crc_d;
            sc_crc_q <= sc_crc_d;
            fc_vld_q <= fc_vld_d;
            sc_vld_q <= sc_vld_d;
            en_q     <= en_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign fc_gnt_o         = fc_gnt_q;
    assign sc_gnt_o         = sc_gnt_q;
    assign fc_crc_o         = fc_crc_q;
    assign sc_crc_o         = sc_crc_q;
    assign fc_crc_valid_o   = fc_vld_q;
    assign sc_crc_valid_o   = sc_vld_q;
    assign enable_crc_gen_o = en_q;
    assign data_gen_crc_o   = data_q;
    assign busy_o           = busy_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_sent_tx_crc_ctrl.sv
// Self-checking bench for sent_tx_crc_ctrl with a behavioural CRC generator responder.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_sent_tx_crc_ctrl;

    localparam int unsigned T = 4;

    logic        clk_tx = 1'b0;
    logic        reset_n_tx;
    logic        fc_req_i;
    logic [1:0]  fc_len_i;
    logic [23:0] fc_data_i;
    logic        fc_gnt_o;
    logic [3:0]  fc_crc_o;
    logic        fc_crc_valid_o;
    logic        sc_req_i;
    logic [23:0] sc_data_i;
    logic        sc_gnt_o;
    logic [5:0]  sc_crc_o;
    logic        sc_crc_valid_o;
    logic [2:0]  enable_crc_gen_o;
    logic [23:0] data_gen_crc_o;
    logic [5:0]  crc_gen_i;
    logic [1:0]  done_i;
    logic        busy_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // generator model: 0 = answer with matching code, 1 = never answer, 2 = wrong code
    int          gen_mode = 0;
    logic [5:0]  gen_crc  = '0;
    bit          gen_armed;
    logic [1:0]  gen_code;

    // model of the held CRC outputs
    logic [3:0]  exp_fc_crc;
    logic [5:0]  exp_sc_crc;

    sent_tx_crc_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk_tx           (clk_tx),
        .reset_n_tx       (reset_n_tx),
        .fc_req_i         (fc_req_i),
        .fc_len_i         (fc_len_i),
        .fc_data_i        (fc_data_i),
        .fc_gnt_o         (fc_gnt_o),
        .fc_crc_o         (fc_crc_o),
        .fc_crc_valid_o   (fc_crc_valid_o),
        .sc_req_i         (sc_req_i),
        .sc_data_i        (sc_data_i),
        .sc_gnt_o         (sc_gnt_o),
        .sc_crc_o         (sc_crc_o),
        .sc_crc_valid_o   (sc_crc_valid_o),
        .enable_crc_gen_o (enable_crc_gen_o),
        .data_gen_crc_o   (data_gen_crc_o),
        .crc_gen_i        (crc_gen_i),
        .done_i           (done_i),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    always #5 clk_tx = ~clk_tx;

    always @(posedge clk_tx) cyc <= cyc + 1;

    // Generator sees the enable in the issue cycle and answers during the following cycle
    always @(negedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            gen_armed = 1'b0;
            done_i    = 2'b00;
            crc_gen_i = 6'h00;
        end else begin
            if (gen_armed) begin
                done_i    = gen_code;
                crc_gen_i = gen_crc;
                gen_armed = 1'b0;
            end else begin
                done_i    = 2'b00;
            end
            if (enable_crc_gen_o != 3'b000 && gen_mode != 1) begin
                gen_armed = 1'b1;
                gen_code  = (enable_crc_gen_o == 3'b101) ? 2'b10 : 2'b01;
                if (gen_mode == 2) gen_code = ~gen_code;
            end
        end
    end

    function automatic logic [2:0] ref_mode(input bit is_sc, input logic [1:0] len);
        if (is_sc) return 3'b101;
        case (len)
            2'd0: return 3'b011;
            2'd1: return 3'b010;
            2'd2: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [23:0] ref_data(input bit is_sc, input logic [1:0] len, input logic [23:0] d);
        if (is_sc) return d;
        case (len)
            2'd0: return d % 24'd4096;
            2'd1: return d % 24'd65536;
            default: return d;
        endcase
    endfunction

    task automatic apply_reset();
        reset_n_tx = 1'b0;
        fc_req_i = 1'b0; sc_req_i = 1'b0;
        gen_mode = 0;
        @(negedge clk_tx);
        @(negedge clk_tx);
        reset_n_tx = 1'b1;
        exp_fc_crc = '0;
        exp_sc_crc = '0;
    endtask

    task automatic test_reset();
        @(negedge clk_tx);
        checks++;
        if ({fc_gnt_o, sc_gnt_o, fc_crc_valid_o, sc_crc_valid_o, busy_o, err_o} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=000000",
                {fc_gnt_o, sc_gnt_o, fc_crc_valid_o, sc_crc_valid_o, busy_o, err_o});
        end
        checks++;
        if (enable_crc_gen_o !== 3'b000 || data_gen_crc_o !== 24'h0) begin
            failures++; $display("FAIL reset_gen got=%b/%h exp=000/000000", enable_crc_gen_o, data_gen_crc_o);
        end
        checks++;
        if (fc_crc_o !== 4'h0 || sc_crc_o !== 6'h00) begin
            failures++; $display("FAIL reset_crc got=%h/%h exp=0/00", fc_crc_o, sc_crc_o);
        end
    endtask

    // One job through IDLE -> ISSUE -> WAIT -> RESP -> IDLE, checked cycle by cycle
    task automatic test_job(input bit is_sc, input logic [1:0] len, input logic [23:0] data,
                            input logic [5:0] crc);
        logic [2:0]  em;
        logic [23:0] ed;
        em = ref_mode(is_sc, len);
        ed = ref_data(is_sc, len, data);
        @(negedge clk_tx);
        gen_mode = 0;
        gen_crc  = crc;
        if (is_sc) begin sc_req_i = 1'b1; sc_data_i = data; end
        else begin fc_req_i = 1'b1; fc_len_i = len; fc_data_i = data; end
        @(negedge clk_tx);
        checks++;
        if ({fc_gnt_o, sc_gnt_o} !== {~is_sc, is_sc}) begin
            failures++; $display("FAIL job_gnt got=%b exp=%b", {fc_gnt_o, sc_gnt_o}, {~is_sc, is_sc});
        end
        checks++;
        if (enable_crc_gen_o !== em) begin
            failures++; $display("FAIL job_enable got=%b exp=%b", enable_crc_gen_o, em);
        end
        checks++;
        if (data_gen_crc_o !== ed) begin
            failures++; $display("FAIL job_data got=%h exp=%h", data_gen_crc_o, ed);
        end
        checks++;
        if (busy_o !== 1'b1 || err_o !== 1'b0) begin
            failures++; $display("FAIL job_issue_busy_err got=%b%b exp=10", busy_o, err_o);
        end
        fc_req_i = 1'b0; sc_req_i = 1'b0;
        @(negedge clk_tx);
        checks++;
        if (enable_crc_gen_o !== 3'b000 || data_gen_crc_o !== ed) begin
            failures++; $display("FAIL job_wait_gen got=%b/%h exp=000/%h", enable_crc_gen_o, data_gen_crc_o, ed);
        end
        @(negedge clk_tx);
        if (is_sc) exp_sc_crc = crc; else exp_fc_crc = crc[3:0];
        checks++;
        if ({fc_crc_valid_o, sc_crc_valid_o} !== {~is_sc, is_sc} || err_o !== 1'b0) begin
            failures++; $display("FAIL job_valid got=%b err=%b exp=%b", {fc_crc_valid_o, sc_crc_valid_o},
                err_o, {~is_sc, is_sc});
        end
        checks++;
        if (fc_crc_o !== exp_fc_crc || sc_crc_o !== exp_sc_crc) begin
            failures++; $display("FAIL job_crc got=%h/%h exp=%h/%h", fc_crc_o, sc_crc_o, exp_fc_crc, exp_sc_crc);
        end
        @(negedge clk_tx);
        checks++;
        if (busy_o !== 1'b0 || {fc_crc_valid_o, sc_crc_valid_o} !== 2'b00 ||
            fc_crc_o !== exp_fc_crc || sc_crc_o !== exp_sc_crc) begin
            failures++; $display("FAIL job_idle_hold got busy=%b vld=%b crc=%h/%h exp busy=0 vld=00 crc=%h/%h",
                busy_o, {fc_crc_valid_o, sc_crc_valid_o}, fc_crc_o, sc_crc_o, exp_fc_crc, exp_sc_crc);
        end
    endtask

    task automatic test_plan_vectors();
        test_job(1'b0, 2'd2, 24'hABC123, 6'h05);
        test_job(1'b0, 2'd0, 24'hFFF5A3, 6'h0C);
        test_job(1'b1, 2'd0, 24'h123456, 6'h2A);
        test_job(1'b0, 2'd1, 24'h9876FE, 6'h3B);
    endtask

    task automatic test_random_jobs();
        for (int i = 0; i < 20; i++) begin
            test_job(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 24'($urandom), 6'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        int   gcyc[4];
        bit   gsc[4];
        logic [5:0] c;
        apply_reset();
        c = 6'($urandom);
        gen_crc = c;
        n = 0;
        @(negedge clk_tx);
        fc_req_i = 1'b1; fc_len_i = 2'd1; fc_data_i = 24'($urandom);
        sc_req_i = 1'b1; sc_data_i = 24'($urandom);
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk_tx);
            if (fc_gnt_o || sc_gnt_o) begin
                gcyc[n] = cyc;
                gsc[n]  = sc_gnt_o;
                n++;
            end
        end
        fc_req_i = 1'b0; sc_req_i = 1'b0;
        checks++;
        if (n != 4) begin
            failures++; $display("FAIL b2b_count got=%0d exp=4", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (gsc[i] !== (i % 2 == 1)) begin
                failures++; $display("FAIL b2b_order job=%0d got_sc=%b exp_sc=%b", i, gsc[i], (i % 2 == 1));
            end
            if (i > 0) begin
                checks++;
                if (gcyc[i] - gcyc[i-1] != 4) begin
                    failures++; $display("FAIL b2b_spacing job=%0d got=%0d exp=4", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
        repeat (4) @(negedge clk_tx);
        exp_fc_crc = c[3:0];
        exp_sc_crc = c;
        checks++;
        if (fc_crc_o !== exp_fc_crc || sc_crc_o !== exp_sc_crc || busy_o !== 1'b0) begin
            failures++; $display("FAIL b2b_final got=%h/%h busy=%b exp=%h/%h busy=0",
                fc_crc_o, sc_crc_o, busy_o, exp_fc_crc, exp_sc_crc);
        end
    endtask

    task automatic test_invalid_len();
        int vld_seen;
        @(negedge clk_tx);
        fc_req_i = 1'b1; fc_len_i = 2'd3; fc_data_i = 24'($urandom);
        @(negedge clk_tx);
        checks++;
        if (fc_gnt_o !== 1'b1 || err_o !== 1'b1 || enable_crc_gen_o !== 3'b000) begin
            failures++; $display("FAIL inv_len_issue got gnt=%b err=%b en=%b exp gnt=1 err=1 en=000",
                fc_gnt_o, err_o, enable_crc_gen_o);
        end
        fc_req_i = 1'b0;
        @(negedge clk_tx);
        checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            failures++; $display("FAIL inv_len_idle got busy=%b err=%b exp=0 0", busy_o, err_o);
        end
        vld_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (fc_crc_valid_o || sc_crc_valid_o || enable_crc_gen_o != 3'b000) vld_seen++;
            @(negedge clk_tx);
        end
        checks++;
        if (vld_seen != 0) begin
            failures++; $display("FAIL inv_len_quiet got=%0d exp=0", vld_seen);
        end
    endtask

    task automatic test_timeout();
        int bad;
        @(negedge clk_tx);
        gen_mode = 1;
        fc_req_i = 1'b1; fc_len_i = 2'd0; fc_data_i = 24'($urandom);
        @(negedge clk_tx);
        checks++;
        if (fc_gnt_o !== 1'b1 || enable_crc_gen_o !== 3'b011) begin
            failures++; $display("FAIL to_issue got gnt=%b en=%b exp gnt=1 en=011", fc_gnt_o, enable_crc_gen_o);
        end
        fc_req_i = 1'b0;
        bad = 0;
        for (int i = 0; i < int'(T); i++) begin
            @(negedge clk_tx);
            if (err_o !== 1'b0 || busy_o !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL to_wait_early_err got=%0d exp=0", bad);
        end
        @(negedge clk_tx);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || {fc_crc_valid_o, sc_crc_valid_o} !== 2'b00) begin
            failures++; $display("FAIL to_err got err=%b busy=%b vld=%b exp err=1 busy=0 vld=00",
                err_o, busy_o, {fc_crc_valid_o, sc_crc_valid_o});
        end
        @(negedge clk_tx);
        checks++;
        if (err_o !== 1'b0 || fc_crc_o !== exp_fc_crc) begin
            failures++; $display("FAIL to_after got err=%b crc=%h exp err=0 crc=%h", err_o, fc_crc_o, exp_fc_crc);
        end
        gen_mode = 0;
    endtask

    task automatic test_done_mismatch();
        @(negedge clk_tx);
        gen_mode = 2;
        gen_crc  = 6'($urandom);
        sc_req_i = 1'b1; sc_data_i = 24'($urandom);
        @(negedge clk_tx);
        sc_req_i = 1'b0;
        @(negedge clk_tx);
        @(negedge clk_tx);
        checks++;
        if (err_o !== 1'b1 || {fc_crc_valid_o, sc_crc_valid_o} !== 2'b00 || sc_crc_o !== exp_sc_crc) begin
            failures++; $display("FAIL mismatch got err=%b vld=%b crc=%h exp err=1 vld=00 crc=%h",
                err_o, {fc_crc_valid_o, sc_crc_valid_o}, sc_crc_o, exp_sc_crc);
        end
        gen_mode = 0;
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk_tx);
        gen_mode = 1;
        fc_req_i = 1'b1; fc_len_i = 2'd2; fc_data_i = 24'($urandom);
        @(negedge clk_tx);
        fc_req_i = 1'b0;
        @(negedge clk_tx);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++; $display("FAIL rst_mid_busy got=%b exp=1", busy_o);
        end
        reset_n_tx = 1'b0;
        #1;
        checks++;
        if ({fc_gnt_o, sc_gnt_o, fc_crc_valid_o, sc_crc_valid_o, busy_o, err_o, enable_crc_gen_o,
             data_gen_crc_o, fc_crc_o, sc_crc_o} !== 43'b0) begin
            failures++; $display("FAIL rst_mid_outputs got en=%b data=%h busy=%b crc=%h/%h exp all zero",
                enable_crc_gen_o, data_gen_crc_o, busy_o, fc_crc_o, sc_crc_o);
        end
        @(negedge clk_tx);
        reset_n_tx = 1'b1;
        gen_mode   = 0;
        exp_fc_crc = '0;
        exp_sc_crc = '0;
        test_job(1'b0, 2'd2, 24'($urandom), 6'($urandom));
        test_job(1'b1, 2'd0, 24'($urandom), 6'($urandom));
    endtask

    initial begin
        fc_len_i = 2'd0; fc_data_i = '0; sc_data_i = '0;
        apply_reset();
        test_reset();
        test_plan_vectors();
        test_random_jobs();
        test_back_to_back();
        test_invalid_len();
        test_timeout();
        test_done_mismatch();
        test_reset_mid_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sent_tx_crc_ctrl.md
# sent_tx_crc_ctrl

Controller and arbiter that shares the single SENT TX CRC generator between the fast-channel frame builder and the slow-channel enhanced serial message builder. It accepts one CRC request at a time, selects the generator mode code, masks and presents the data word, and waits for the generator's done code. It then returns the CRC to the requester that was served. It sits between the two frame builders and the CRC generator in the TX path.

## Interface
- TIMEOUT_CYC, 4: max cycles spent in WAIT before a timeout error (range 2..7).
- clk_tx  in  1  TX clock, rising edge.
- reset_n_tx  in  1  one clock; reset is asynchronous and active-low.
- fc_req_i  in  1  fast-channel request; held until fc_gnt_o.
- fc_len_i  in  2  fast-channel data nibbles: 0=3, 1=4, 2=6, 3=invalid.
- fc_data_i  in  24  fast-channel data, nibble-packed, LSB-aligned.
- fc_gnt_o  out  1  one-cycle accept pulse.
- fc_crc_o  out  4  fast-channel CRC, valid with fc_crc_valid_o.
- fc_crc_valid_o  out  1  one-cycle result pulse.
- sc_req_i  in  1  slow-channel request; held until sc_gnt_o.
- sc_data_i  in  24  enhanced serial message bits.
- sc_gnt_o  out  1  one-cycle accept pulse.
- sc_crc_o  out  6  serial CRC, valid with sc_crc_valid_o.
- sc_crc_valid_o  out  1  one-cycle result pulse.
- enable_crc_gen_o  out  3  mode code to the generator; nonzero for exactly one cycle per job.
- data_gen_crc_o  out  24  data to the generator.
- crc_gen_i  in  6  generator result.
- done_i  in  2  generator done code: 01 = 4-bit CRC, 10 = 6-bit CRC.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  one-cycle pulse on invalid length, timeout or done-code mismatch.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - With one request pending, that requester wins.
  - With both pending, the requester not served last wins (round-robin). The `last` flag resets to slow, so fast wins the first tie.
  - The winner's data, length and identity are latched and the FSM goes to ISSUE.
- ISSUE:
  - The winner's gnt pulses. `last` is updated.
  - Mode codes: fast len 0 → 3'b011 with data[11:0] and upper bits zeroed; len 1 → 3'b010 with data[15:0]; len 2 → 3'b001 with data[23:0]. Slow → 3'b101 with the full 24 bits.
  - Fast len 3: no code is issued (enable stays 000), err_o pulses, and the FSM returns to IDLE.
- WAIT:
  - enable_crc_gen_o is 000; data_gen_crc_o holds.
  - When done_i != 0, crc_gen_i is latched. The expected done code is 01 for fast and 10 for slow; a mismatch pulses err_o and the FSM returns to IDLE with no result pulse.
  - If done_i stays 0 for TIMEOUT_CYC cycles, err_o pulses and the FSM returns to IDLE.
- RESP:
  - The served requester's crc_valid pulses. fast gets crc[3:0]; slow gets crc[5:0].
  - The CRC outputs hold their value until the next RESP. The FSM then goes to IDLE.
- A request still asserted after its gnt is treated as a new job.

## Timing
- Cycle t: request sampled in IDLE.
- t+1: ISSUE; gnt and enable code are driven.
- t+2: WAIT; done_i sampled (the generator answers one cycle after the enable).
- t+3: RESP; crc_valid.
- t+4: IDLE.
- Best-case throughput is one job per 4 cycles.
- Reset values: all outputs 0 (CRC outputs 0, enable 000, data 0); state IDLE; `last`=slow; timeout counter 0.
- Reset mid-job aborts the job: no gnt or valid pulse, and the requester must re-request.
- A request arriving during busy is ignored until IDLE; no request is queued.
- The timeout counter saturates and is cleared on entry to WAIT.

## Structure
- The shared package sent_tx_pkg holds:
  - Mode-code constants: CRC_FC6=3'b001, CRC_FC4=3'b010, CRC_FC3=3'b011, CRC_SER=3'b101.
  - Done codes: DONE_4B=2'b01, DONE_6B=2'b10.
  - The fc_len enum.
  - The FSM state enum.
- One sub-module is natural: sent_tx_rr_arb2, a two-input round-robin arbiter holding the `last` flag.

## Test plan
- fast req, len=2, data 24'hABC123; generator model answers crc 6'h05 with done 01 → enable 3'b001 and data 24'hABC123 at t+1; fc_crc_o=4'h5 and fc_crc_valid_o at t+3.
- fast len=0, data 24'hFFF5A3 → data_gen_crc_o=24'h0005A3, enable 3'b011; result returned at t+3.
- slow req, data 24'h123456; model crc 6'h2A with done 10 → enable 3'b101; sc_crc_o=6'h2A at t+3.
- Both requesting continuously for 4 jobs → grants alternate F,S,F,S with gnts 4 cycles apart.
- fast len=3 → fc_gnt_o and err_o in the same cycle, enable stays 000, no valid pulse; model never answers → err_o after TIMEOUT_CYC cycles in WAIT.
- reset_n_tx asserted during WAIT → all outputs 0 immediately; after release, a new request is served normally.
